conv_sequencer: RTL and testbench

CONV_SEQUENCER -- requirements
Module: conv_sequencer

---
 rtl/conv_sequencer.sv | 112 +++++++++++
 tb/tb_conv_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sequencer.sv
// Convolution layer sequencer: steps taps per output and output positions per layer, driving the MAC handshake.
// Optional feature: define CONV_SEQ_ABORT_EN to add an abort input that drops the layer back to IDLE.
module conv_sequencer #(
   parameter int TAPS  = 9,
   parameter int NOUT  = 36,
   parameter int TAP_W = 4,
   parameter int OUT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_ready,
   input  logic             out_ready,
`ifdef CONV_SEQ_ABORT_EN
   input  logic             abort,
`endif
   output logic [TAP_W-1:0] tap,
   output logic [OUT_W-1:0] out_idx,
   output logic             mac_en,
   output logic             acc_clr,
   output logic             out_valid,
   output logic             busy,
   output logic             complete
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ACCUM,
      S_EMIT,
      S_DONE
   } state_t;

   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);
   localparam logic [OUT_W-1:0] LAST_OUT = OUT_W'(NOUT - 1);

   state_t             r_state;
   logic [TAP_W-1:0]   r_tap;
   logic [OUT_W-1:0]   r_outIdx;
   logic               w_abort;

`ifdef CONV_SEQ_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   // Abort outranks every transition; in IDLE it also masks a simultaneous start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_tap    <= '0;
         r_outIdx <= '0;
      end else if (w_abort && (r_state != S_IDLE)) begin
         r_state  <= S_IDLE;
         r_tap    <= '0;
         r_outIdx <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start && !w_abort) begin
                  r_state  <= S_CLEAR;
                  r_tap    <= '0;
                  r_outIdx <= '0;
               end
            end
            S_CLEAR: begin
               r_state <= S_ACCUM;
            end
            S_ACCUM: begin
               if (in_ready) begin
                  if (r_tap == LAST_TAP) begin
                     r_tap   <= '0;
                     r_state <= S_EMIT;
                  end else begin
                     r_tap <= r_tap + 1'b1;
                  end
               end
            end
            S_EMIT: begin
               if (out_ready) begin
                  if (r_outIdx == LAST_OUT) begin
                     r_state <= S_DONE;
                  end else begin
                     r_outIdx <= r_outIdx + 1'b1;
                     r_state  <= S_CLEAR;
                  end
               end
            end
            S_DONE: begin
               r_outIdx <= '0;
               r_state  <= S_IDLE;
            end
            default: begin
               r_state  <= S_IDLE;
               r_tap    <= '0;
               r_outIdx <= '0;
            end
         endcase
      end
   end

   // Strobes decode only the registered state, so reset clears them without waiting for a clock.
   assign tap       = r_tap;
   assign out_idx   = r_outIdx;
   assign mac_en    = (r_state == S_ACCUM) && in_ready;
   assign acc_clr   = (r_state == S_CLEAR);
   assign out_valid = (r_state == S_EMIT);
   assign complete  = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: a loop-structured layer model is compared every cycle,
// plus literal checks on latency, pulse counts, stalls, ignored start and async reset.
module tb_conv_sequencer;

   localparam int TAPS  = 9;
   localparam int NOUT  = 36;
   localparam int TAP_W = 4;
   localparam int OUT_W = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic inReady = 1'b1;
   logic outReady = 1'b1;
`ifdef CONV_SEQ_ABORT_EN
   logic abort = 1'b0;
`endif

   logic [TAP_W-1:0] tap;
   logic [OUT_W-1:0] out_idx;
   logic mac_en, acc_clr, out_valid, busy, complete;

   int compared = 0;
   int mismatched = 0;

   int expTap = 0, expIdx = 0;
   bit expClr = 0, expAccum = 0, expValid = 0, expBusy = 0, expComplete = 0;

   int clrCount = 0, macCount = 0, completeCount = 0, macSinceClr = 0;
   bit prevValid = 0;

   conv_sequencer #(.TAPS(TAPS), .NOUT(NOUT), .TAP_W(TAP_W), .OUT_W(OUT_W)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .in_ready(inReady),
      .out_ready(outReady),
`ifdef CONV_SEQ_ABORT_EN
      .abort(abort),
`endif
      .tap(tap),
      .out_idx(out_idx),
      .mac_en(mac_en),
      .acc_clr(acc_clr),
      .out_valid(out_valid),
      .busy(busy),
      .complete(complete)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
      end
   endtask

   // Called at a falling edge; inputs change 1 time unit later, well clear of the rising edge.
   task automatic applyStimulus(input bit s, input bit ir, input bit orr);
      #1;
      start    = s;
      inReady  = ir;
      outReady = orr;
   endtask

   // Model: one layer is a nest of loops over outputs and taps, advanced one rising edge at a time.
   task automatic step(output bit killed);
      @(posedge clk or posedge rst);
`ifdef CONV_SEQ_ABORT_EN
      killed = rst || abort;
`else
      killed = rst;
`endif
   endtask

   task automatic setIdle();
      expTap = 0; expIdx = 0; expClr = 0; expAccum = 0;
      expValid = 0; expBusy = 0; expComplete = 0;
   endtask

   task automatic runLayer();
      bit k;
      setIdle();
      do begin
         step(k);
         if (k) return;
      end while (!start);
      for (int o = 0; o < NOUT; o++) begin
         expBusy = 1; expIdx = o; expTap = 0; expClr = 1; expAccum = 0; expValid = 0;
         step(k);
         if (k) return;
         expClr = 0; expAccum = 1;
         for (int t = 0; t < TAPS; t++) begin
            expTap = t;
            do begin
               step(k);
               if (k) return;
            end while (!inReady);
         end
         expTap = 0; expAccum = 0; expValid = 1;
         do begin
            step(k);
            if (k) return;
         end while (!outReady);
         expValid = 0;
      end
      expIdx = NOUT - 1; expComplete = 1;
      step(k);
   endtask

   initial begin
      forever runLayer();
   end

   always @(negedge clk) begin
      checkOutput("tap", tap, expTap);
      checkOutput("out_idx", out_idx, expIdx);
      checkOutput("acc_clr", acc_clr, expClr);
      checkOutput("mac_en", mac_en, int'(expAccum && inReady));
      checkOutput("out_valid", out_valid, expValid);
      checkOutput("busy", busy, expBusy);
      checkOutput("complete", complete, expComplete);
      if (acc_clr) begin
         clrCount++;
         macSinceClr = 0;
      end
      if (mac_en) begin
         macCount++;
         macSinceClr++;
      end
      if (complete) completeCount++;
      if (out_valid && !prevValid) checkOutput("macPerOutput", macSinceClr, TAPS);
      prevValid = out_valid;
   end

   task automatic resetCounters();
      clrCount = 0; macCount = 0; completeCount = 0;
   endtask

   task automatic waitFor(input int idx, input int tp, input bit wantValid, input string name);
      int n = 0;
      while (n < 2000) begin
         @(negedge clk);
         if ((out_idx == idx) && (tp < 0 || tap == tp) && (wantValid ? out_valid : mac_en)) return;
         n++;
      end
      checkOutput({name, "Timeout"}, 0, 1);
   endtask

   task automatic waitComplete(input string name);
      int n = 0;
      while (n < 2000) begin
         @(negedge clk);
         if (complete) return;
         n++;
      end
      checkOutput({name, "Timeout"}, 0, 1);
   endtask

   // Full uninterrupted layer: complete must appear 396 edges after the start edge.
   task automatic runFullLayer(input string name);
      int n = 0;
      @(negedge clk);
      resetCounters();
      applyStimulus(1, 1, 1);
      @(posedge clk);
      while (n < 2000) begin
         @(negedge clk);
         if (complete) break;
         if (n == 0) #1 start = 0;
         @(posedge clk);
         n++;
      end
      checkOutput({name, "Latency"}, n, 396);
      repeat (3) @(negedge clk);
      #1;
      checkOutput({name, "ClrPulses"}, clrCount, 36);
      checkOutput({name, "MacCycles"}, macCount, 324);
      checkOutput({name, "Completes"}, completeCount, 1);
      checkOutput({name, "BusyAfter"}, busy, 0);
   endtask

   initial begin
      int cnt;
      repeat (2) @(negedge clk);
      checkOutput("resetBusy", busy, 0);
      checkOutput("resetTap", tap, 0);
      checkOutput("resetIdx", out_idx, 0);
      checkOutput("resetComplete", complete, 0);
      #1 rst = 0;
      repeat (2) @(negedge clk);

      runFullLayer("layer1");

      // Layer with an input stall, an output stall and an ignored start.
      @(negedge clk);
      resetCounters();
      applyStimulus(1, 1, 1);
      @(negedge clk);
      applyStimulus(0, 1, 1);
      waitFor(0, 4, 0, "stallWait");
      applyStimulus(0, 0, 1);
      repeat (3) begin
         @(negedge clk);
         checkOutput("stallTap", tap, 4);
         checkOutput("stallMac", mac_en, 0);
      end
      applyStimulus(0, 1, 1);
      waitFor(7, -1, 1, "emitWait");
      applyStimulus(0, 1, 0);
      cnt = 1;
      repeat (5) begin
         @(negedge clk);
         if (out_valid && out_idx == 7) cnt++;
      end
      applyStimulus(0, 1, 1);
      @(negedge clk);
      checkOutput("emitHoldCycles", cnt, 6);
      checkOutput("afterEmitIdx", out_idx, 8);
      checkOutput("afterEmitClr", acc_clr, 1);
      waitFor(10, -1, 0, "restartWait");
      applyStimulus(1, 1, 1);
      @(negedge clk);
      applyStimulus(0, 1, 1);
      checkOutput("restartIgnoredIdx", out_idx, 10);
      checkOutput("restartIgnoredBusy", busy, 1);
      waitComplete("layer2");
      repeat (3) @(negedge clk);
      #1;
      checkOutput("layer2Completes", completeCount, 1);
      checkOutput("layer2BusyAfter", busy, 0);

      // Asynchronous reset mid-layer, away from any clock edge.
      @(negedge clk);
      resetCounters();
      applyStimulus(1, 1, 1);
      @(negedge clk);
      applyStimulus(0, 1, 1);
      waitFor(20, 3, 0, "resetWait");
      #1 rst = 1;
      #1;
      checkOutput("asyncTap", tap, 0);
      checkOutput("asyncIdx", out_idx, 0);
      checkOutput("asyncMac", mac_en, 0);
      checkOutput("asyncClr", acc_clr, 0);
      checkOutput("asyncValid", out_valid, 0);
      checkOutput("asyncBusy", busy, 0);
      checkOutput("asyncComplete", complete, 0);
      repeat (2) @(negedge clk);
      #1 rst = 0;
      repeat (20) @(negedge clk);
      #1;
      checkOutput("noCompleteAfterReset", completeCount, 0);
      checkOutput("idleAfterReset", busy, 0);
      runFullLayer("layer3");

`ifdef CONV_SEQ_ABORT_EN
      @(negedge clk);
      resetCounters();
      applyStimulus(1, 1, 1);
      @(negedge clk);
      applyStimulus(0, 1, 1);
      waitFor(5, 2, 0, "abortWait");
      #1 abort = 1;
      @(negedge clk);
      checkOutput("abortBusy", busy, 0);
      checkOutput("abortTap", tap, 0);
      checkOutput("abortIdx", out_idx, 0);
      #1 abort = 1; start = 1;
      @(negedge clk);
      checkOutput("abortStartIdle", busy, 0);
      #1 abort = 0; start = 0;
      repeat (15) @(negedge clk);
      #1;
      checkOutput("abortNoComplete", completeCount, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
